ip4_ram_arb: RTL and testbench
==============================

# ip4_ram_arb

Round-robin arbiter and sequencer that shares one `ip4_ram` single-port SRAM instance between `NUM_REQ` requesters. Each cycle it grants at most one access, drives the RAM's address, write and byte-enable ports, and returns read data to the requester that issued the read. It also supports locked bursts with a bounded length and sits directly between the requesting engines and the RAM wrapper.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8
- `ADDR_WIDTH`, 10: RAM address width; must match the RAM's `addr_width`
- `WORD_WIDTH`, 32: data width; must match the RAM's `word_width`
- `BE_WIDTH`, (WORD_WIDTH-1)/8+1: byte-enable width
- `MAX_BURST`, 8: maximum accepted beats per locked burst, at least 1
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req`  in  NUM_REQ  per-requester access request
- `lock`  in  NUM_REQ  per-requester burst hold
- `we`  in  NUM_REQ  1 = write, 0 = read
- `addr`  in  NUM_REQ x ADDR_WIDTH  access address
- `be`  in  NUM_REQ x BE_WIDTH  write byte enables
- `wdata`  in  NUM_REQ x WORD_WIDTH  write data
- `gnt`  out  NUM_REQ  one-hot grant (combinational); an access is accepted when `req[i] & gnt[i]`
- `rvalid`  out  NUM_REQ  one-hot read-response strobe
- `rdata`  out  WORD_WIDTH  read data; valid only while some `rvalid` bit is high
- `ram_radr`, `ram_wadr`  out  ADDR_WIDTH  RAM read and write addresses
- `ram_wr`  out  1  RAM write strobe
- `ram_be`  out  BE_WIDTH  RAM byte enables
- `ram_datai`  out  WORD_WIDTH  RAM write data
- `ram_datao`, `ram_datao_d`  in  WORD_WIDTH  RAM read data, unregistered and registered

## Operation
- **States:** `IDLE` and `BURST`. Registered state consists of the state, the round-robin pointer `ptr`, the burst owner `own`, the beat counter `cnt`, and the read-tag pipeline.
- **`IDLE` arbitration:** `gnt` selects the first requester with `req` set, searching from `ptr` upward and wrapping modulo `NUM_REQ`.
  - On an accepted access with `lock` low: `ptr` becomes winner+1 (mod `NUM_REQ`).
  - On an accepted access with `lock` high: go to `BURST`, set `own` to the winner and `cnt` to 1. `ptr` is not changed.
  - With `MAX_BURST`=1, a locked access does not enter `BURST`; it is treated as unlocked and `ptr` advances.
- **`BURST`:**
  - `gnt = req[own]` on bit `own`. All other requesters see `gnt` = 0.
  - Each accepted beat increments `cnt`.
  - The burst ends when any of the following occurs:
    - `req[own]` is low;
    - the accepted beat has `lock[own]` low;
    - the accepted beat brings `cnt` to `MAX_BURST` (forced release).
  - On burst end: return to `IDLE` with `ptr` = own+1.
  - When the burst ends because `req[own]` is low, no beat is issued that cycle, but arbitration among the other requesters in that same cycle uses the old `ptr`.
- **RAM drive:**
  - When an access is accepted: `ram_radr` and `ram_wadr` take the granted `addr`, `ram_be` and `ram_datai` take the granted `be`/`wdata`, and `ram_wr` = granted `we`.
  - When nothing is accepted: `ram_wr` = 0 and the address and data outputs are 0.
- **Read tag:** an accepted read loads the one-hot requester id into the tag pipeline. Writes produce no response.
- **Reset:** with `rst` high, `gnt`, `rvalid` and `ram_wr` are forced to 0; state returns to `IDLE`; `ptr`, `own` and `cnt` are cleared to 0; the tag pipeline is cleared. Reads in flight when reset asserts never produce a response.

## Timing
- `gnt` and the RAM drive outputs are combinational from `req`/`lock`/`we` and registered state. The request-to-accept decision happens in the same cycle.
- Read latency without the macro: a read accepted in cycle N gives `rvalid` in N+1, with `rdata` = `ram_datao`.
- Back-to-back accepted reads give back-to-back responses in request order. Throughput is 1 access per cycle.
- A write accepted in cycle N followed by a read of the same address in N+1 returns the new data. Because reads never directly follow their own write cycle, the RAM's X output after a write is never sampled.
- Reset values: all outputs are 0 except `rdata`, which is don't-care.

## Configuration
- `IP4_RAM_ARB_RDREG_EN` defined:
  - the tag pipeline gains a second stage;
  - `rvalid` asserts in N+2;
  - `rdata` = `ram_datao_d`.
- Not defined: single-stage tag, `rvalid` in N+1, `rdata` = `ram_datao`.
- Arbitration behaviour is identical in both builds.

## Structure
- Package `ip4_ram_arb_pkg` holds:
  - the state enum `arb_state_e {IDLE, BURST}`;
  - the constant `IP4_RAM_ARB_MAX_REQ` = 8;
  - the function `rr_onehot`, used for the pointer wrap.
- Sub-module `ip4_rr_pick` is a combinational round-robin picker. Inputs are `req` and `ptr`; outputs are the one-hot winner and its index. It is instantiated once in `IDLE` arbitration.

## Test plan
- After reset, `req`=2'b11 on every cycle with `lock`=0 → grants alternate 01, 10, 01, 10; `ram_wr` stays 0 during the 2 reset cycles.
- Requester 0 writes 0xDEADBEEF to address 0x3 with `be`=4'b0101; in the next cycle requester 1 reads 0x3 → `rvalid`=2'b10 one cycle later (two with `IP4_RAM_ARB_RDREG_EN`), `rdata` = 0x00AD00EF when the address was previously 0.
- Requester 1 holds `req` and `lock` for 12 cycles with `MAX_BURST`=8 while requester 0 also requests → requester 1 gets exactly 8 beats, then requester 0 is granted on the 9th cycle.
- Requester 0 drops `lock` on its 3rd beat → burst ends after 3 beats and `ptr`=1.
- Four consecutive reads to addresses 0..3 holding values 10..13 → four consecutive `rvalid` pulses with `rdata` 10, 11, 12, 13.
- `rst` asserted the cycle after a read is accepted → no `rvalid` pulse, and after reset is released the first grant goes to requester 0.

Source files
------------

// File: rtl/ip4_ram_arb_pkg.sv
// Shared types and helpers for the ip4_ram round-robin arbiter.
package ip4_ram_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_e;

  localparam int unsigned IP4_RAM_ARB_MAX_REQ = 8;

  // One-hot position of the requester that follows idx, wrapping at n.
  function automatic logic [IP4_RAM_ARB_MAX_REQ-1:0] rr_onehot(input int unsigned idx,
                                                               input int unsigned n);
    int unsigned nxt;
    nxt = (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    rr_onehot = '0;
    for (int unsigned b = 0; b < IP4_RAM_ARB_MAX_REQ; b++) begin
      rr_onehot[b] = (b == nxt);
    end
  endfunction

endpackage

// File: rtl/ip4_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module ip4_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic        found;
    int unsigned j;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        win[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ip4_ram_arb.sv
// Round-robin arbiter/sequencer sharing one ip4_ram between NUM_REQ requesters.
// Define IP4_RAM_ARB_RDREG_EN to return read data from the RAM's registered output.
module ip4_ram_arb
  import ip4_ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = (WORD_WIDTH - 1) / 8 + 1,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   lock,
  input  logic [NUM_REQ-1:0]                   we,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_REQ-1:0][BE_WIDTH-1:0]     be,
  input  logic [NUM_REQ-1:0][WORD_WIDTH-1:0]   wdata,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   rvalid,
  output logic [WORD_WIDTH-1:0]                rdata,
  output logic [ADDR_WIDTH-1:0]                ram_radr,
  output logic [ADDR_WIDTH-1:0]                ram_wadr,
  output logic                                 ram_wr,
  output logic [BE_WIDTH-1:0]                  ram_be,
  output logic [WORD_WIDTH-1:0]                ram_datai,
  input  logic [WORD_WIDTH-1:0]                ram_datao,
  input  logic [WORD_WIDTH-1:0]                ram_datao_d
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n, own, own_n, sel;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_REQ-1:0] pick_win, tag_in, tag1;
  logic [IDX_W-1:0]   pick_idx;
  logic               acc, idle_arb;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    logic [IP4_RAM_ARB_MAX_REQ-1:0] oh;
    oh = rr_onehot(32'(i), NUM_REQ);
    next_idx = '0;
    for (int unsigned b = 0; b < NUM_REQ; b++) begin
      if (oh[b]) next_idx = IDX_W'(b);
    end
  endfunction

  ip4_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx)
  );

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    own_n    = own;
    cnt_n    = cnt;
    gnt      = '0;
    acc      = 1'b0;
    sel      = pick_idx;
    idle_arb = 1'b0;
    if (!rst) begin
      if (state == BURST) begin
        if (req[own]) begin
          gnt[own] = 1'b1;
          acc      = 1'b1;
          sel      = own;
          cnt_n    = cnt + CNT_W'(1);
          if (!lock[own] || cnt_n == CNT_W'(MAX_BURST)) begin
            state_n = IDLE;
            ptr_n   = next_idx(own);
          end
        end else begin
          // Owner let go: release, but the others still arbitrate now on the old ptr.
          state_n  = IDLE;
          ptr_n    = next_idx(own);
          idle_arb = 1'b1;
        end
      end else begin
        idle_arb = 1'b1;
      end

      if (idle_arb && (|pick_win)) begin
        gnt = pick_win;
        acc = 1'b1;
        sel = pick_idx;
        if (lock[pick_idx] && MAX_BURST > 1) begin
          state_n = BURST;
          own_n   = pick_idx;
          cnt_n   = CNT_W'(1);
        end else begin
          ptr_n = next_idx(pick_idx);
        end
      end
    end
  end

  always_comb begin
    ram_radr  = '0;
    ram_wadr  = '0;
    ram_be    = '0;
    ram_datai = '0;
    ram_wr    = 1'b0;
    if (acc) begin
      ram_radr  = addr[sel];
      ram_wadr  = addr[sel];
      ram_be    = be[sel];
      ram_datai = wdata[sel];
      ram_wr    = we[sel];
    end
  end

  assign tag_in = gnt & req & ~we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      own   <= '0;
      cnt   <= '0;
      tag1  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      own   <= own_n;
      cnt   <= cnt_n;
      tag1  <= tag_in;
    end
  end

`ifdef IP4_RAM_ARB_RDREG_EN
  logic [NUM_REQ-1:0] tag2;
  logic               unused_datao;

  always_ff @(posedge clk) begin
    if (rst) tag2 <= '0;
    else     tag2 <= tag1;
  end

  assign unused_datao = ^ram_datao;
  assign rvalid       = rst ? '0 : tag2;
  assign rdata        = ram_datao_d;
`else
  logic unused_datao_d;

  assign unused_datao_d = ^ram_datao_d;
  assign rvalid         = rst ? '0 : tag1;
  assign rdata          = ram_datao;
`endif

endmodule

// File: tb/tb_ip4_ram_arb.sv
// Self-checking bench for ip4_ram_arb: directed test-plan steps plus random traffic
// checked against a rule-level arbitration/memory reference model.
module tb_ip4_ram_arb;

  localparam int N    = 2;
  localparam int AW   = 10;
  localparam int WW   = 32;
  localparam int BW   = 4;
  localparam int MAXB = 8;
`ifdef IP4_RAM_ARB_RDREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            req, lock, we;
  logic [N-1:0][AW-1:0]    addr;
  logic [N-1:0][BW-1:0]    be;
  logic [N-1:0][WW-1:0]    wdata;
  logic [N-1:0]            gnt, rvalid;
  logic [WW-1:0]           rdata;
  logic [AW-1:0]           ram_radr, ram_wadr;
  logic                    ram_wr;
  logic [BW-1:0]           ram_be;
  logic [WW-1:0]           ram_datai, ram_datao, ram_datao_d;

  always #5 clk = ~clk;

  ip4_ram_arb #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .WORD_WIDTH (WW),
    .BE_WIDTH   (BW),
    .MAX_BURST  (MAXB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .we          (we),
    .addr        (addr),
    .be          (be),
    .wdata       (wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .ram_radr    (ram_radr),
    .ram_wadr    (ram_wadr),
    .ram_wr      (ram_wr),
    .ram_be      (ram_be),
    .ram_datai   (ram_datai),
    .ram_datao   (ram_datao),
    .ram_datao_d (ram_datao_d)
  );

  // Single-port SRAM stand-in: X on the read port in the cycle after a write.
  logic [WW-1:0] env_mem [0:1023];
  always @(posedge clk) begin
    logic [WW-1:0] w;
    if (ram_wr) begin
      w = env_mem[ram_wadr];
      for (int b = 0; b < BW; b++) if (ram_be[b]) w[8*b +: 8] = ram_datai[8*b +: 8];
      env_mem[ram_wadr] <= w;
      ram_datao <= 'x;
    end else begin
      ram_datao <= env_mem[ram_radr];
    end
    ram_datao_d <= ram_datao;
  end

  // Reference model state.
  logic [WW-1:0] ref_mem [0:1023];
  int  m_ptr, m_own, m_left;
  bit  m_burst;
  typedef struct { int due; logic [N-1:0] oh; logic [WW-1:0] data; } resp_t;
  resp_t rq[$];

  int total = 0, bad = 0, cyc = 0;
  logic [N-1:0]  last_gnt, last_rvalid;
  logic [WW-1:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic idle_accept(input int w);
    if (w >= 0) begin
      if (lock[w] && MAXB > 1) begin
        m_burst = 1; m_own = w; m_left = MAXB - 1;
      end else begin
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  // Returns the requester accepted this cycle (-1 if none) and advances the model.
  task automatic model_eval(output int w);
    int base;
    w = -1;
    if (rst) begin
      m_ptr = 0; m_own = 0; m_left = 0; m_burst = 0;
    end else if (m_burst) begin
      if (req[m_own]) begin
        w = m_own;
        m_left--;
        if (!lock[m_own] || m_left == 0) begin
          m_burst = 0; m_ptr = (m_own + 1) % N;
        end
      end else begin
        base    = m_ptr;
        m_burst = 0;
        m_ptr   = (m_own + 1) % N;
        w       = find(base);
        idle_accept(w);
      end
    end else begin
      w = find(m_ptr);
      idle_accept(w);
    end
  endtask

  task automatic step();
    int            w;
    logic [N-1:0]  e_gnt, e_rv;
    logic [WW-1:0] e_rd, nw;
    @(negedge clk);
    model_eval(w);
    e_gnt = '0;
    if (w >= 0) e_gnt[w] = 1'b1;
    chk("gnt", gnt, e_gnt);
    chk("ram_wr", ram_wr, (w >= 0) ? we[w] : 1'b0);
    chk("ram_radr", ram_radr, (w >= 0) ? addr[w] : '0);
    chk("ram_wadr", ram_wadr, (w >= 0) ? addr[w] : '0);
    chk("ram_be", ram_be, (w >= 0) ? be[w] : '0);
    chk("ram_datai", ram_datai, (w >= 0) ? wdata[w] : '0);
    e_rv = '0;
    e_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv = rq[0].oh;
      e_rd = rq[0].data;
      void'(rq.pop_front());
    end
    if (rst) begin
      e_rv = '0;
      rq.delete();
    end
    chk("rvalid", rvalid, e_rv);
    if (e_rv != '0) chk("rdata", rdata, e_rd);
    last_gnt    = gnt;
    last_rvalid = rvalid;
    last_rdata  = rdata;
    if (w >= 0) begin
      if (we[w]) begin
        nw = ref_mem[addr[w]];
        for (int b = 0; b < BW; b++) if (be[w][b]) nw[8*b +: 8] = wdata[w][8*b +: 8];
        ref_mem[addr[w]] = nw;
      end else begin
        rq.push_back('{cyc + LAT, e_gnt, ref_mem[addr[w]]});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [WW-1:0] got[$];
    int            got_cyc[$];
    int            n1, nrv;

    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_ptr = 0; m_own = 0; m_left = 0; m_burst = 0;
    rst = 1'b1; req = 2'b11; lock = '0; we = '0;
    addr = '0; be = '0; wdata = '0;

    // Reset: two cycles with requests pending, nothing may be granted or written.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ram_wr", ram_wr, 1'b0);
    end
    rst = 1'b0;

    // Alternating grants with both requesting.
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_gnt", last_gnt, (i % 2) ? 2'b10 : 2'b01);
    end

    // Byte-enabled write then read of the same address.
    req = 2'b01; we = 2'b01; addr[0] = 10'h3; be[0] = 4'b0101; wdata[0] = 32'hDEADBEEF;
    step();
    req = 2'b10; we = 2'b00; addr[1] = 10'h3;
    step();
    req = 2'b00;
    for (int i = 0; i < LAT; i++) step();
    chk("wr_rd_valid", last_rvalid, 2'b10);
    chk("wr_rd_data", last_rdata, 32'h00AD00EF);

    // Locked burst from requester 1 is cut at MAX_BURST beats.
    n1 = 0;
    req = 2'b10; lock = 2'b10;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i < 8 && last_gnt == 2'b10) n1++;
      if (i == 8) chk("burst_release_gnt", last_gnt, 2'b01);
      req = 2'b11;
    end
    chk("burst_beats", n1, 8);
    req = 2'b00; lock = 2'b00;
    step();

    // Requester 0 drops lock on its third beat; pointer must move to 1.
    req = 2'b01; lock = 2'b01;
    step();
    step();
    lock = 2'b00;
    step();
    chk("lock_drop_beat3", last_gnt, 2'b01);
    req = 2'b11;
    step();
    chk("ptr_after_burst", last_gnt, 2'b10);

    // Four writes then four back-to-back reads.
    req = 2'b01; lock = 2'b00; we = 2'b01; be[0] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      addr[0] = AW'(i); wdata[0] = WW'(10 + i);
      step();
    end
    we = 2'b00;
    for (int i = 0; i < 4 + LAT + 1; i++) begin
      if (i < 4) addr[0] = AW'(i);
      else req = 2'b00;
      step();
      if (last_rvalid != '0) begin
        got.push_back(last_rdata);
        got_cyc.push_back(cyc);
      end
    end
    chk("b2b_count", got.size(), 4);
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("b2b_data", got[i], WW'(10 + i));
      chk("b2b_spacing", got_cyc[3] - got_cyc[0], 3);
    end

    // Reset right after an accepted read kills the response.
    req = 2'b01; addr[0] = 10'h0;
    step();
    nrv = 0;
    rst = 1'b1; req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst = 1'b0;
      step();
      if (last_rvalid != '0) nrv++;
    end
    chk("rst_kills_read", nrv, 0);
    req = 2'b11;
    step();
    chk("post_rst_gnt", last_gnt, 2'b01);

    // Random traffic.
    for (int t = 0; t < 600; t++) begin
      rst  = ($urandom_range(0, 99) == 0);
      req  = N'($urandom);
      lock = N'($urandom & $urandom);
      we   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        addr[i]  = AW'($urandom_range(0, 15));
        be[i]    = BW'($urandom);
        wdata[i] = $urandom;
      end
      step();
    end
    rst = 1'b0; req = '0; lock = '0;
    for (int i = 0; i < LAT + 1; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
